regfile_scoreboard: RTL and testbench

- Parametrised successor to the core's 32x32 register file: configurable width and depth, hardwired zero register, write-to-read bypass, asynchronous clear.
- Adds a per-register busy scoreboard so a pipelined core can detect RAW and WAW hazards against in-flight writes.
- Sits between decode (read and issue ports) and writeback (write port).

---
 rtl/regfile_scoreboard_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 124 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the scoreboarded register file: two read ports,
// one writeback port and one issue port.
interface regfile_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] readRegister1;
  logic [ADDR_WIDTH-1:0] readRegister2;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;
  logic                  busy1;
  logic                  busy2;
  logic                  regWrite;
  logic [ADDR_WIDTH-1:0] writeRegister;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  issueValid;
  logic [ADDR_WIDTH-1:0] issueRegister;
  logic                  issueReady;
  logic [ADDR_WIDTH:0]   pendingCount;

  // Pipeline side: decode drives read/issue indices, writeback drives the write port.
  modport master (
    output readRegister1, readRegister2, regWrite, writeRegister, writeData,
           issueValid, issueRegister,
    input  readData1, readData2, busy1, busy2, issueReady, pendingCount
  );

  modport slave (
    input  readRegister1, readRegister2, regWrite, writeRegister, writeData,
           issueValid, issueRegister,
    output readData1, readData2, busy1, busy2, issueReady, pendingCount
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write-to-read bypass, optional hardwired zero
// register and a per-register busy scoreboard for RAW/WAW hazard detection.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  rf
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH:0]   pendingCount_q, pendingCount_d;

  logic                  writeEnable;
  logic                  accept;
  logic                  setsNewBit;
  logic                  clearsOldBit;
  logic                  bypassHit1, bypassHit2;
  logic [DATA_WIDTH-1:0] readData1, readData2;
  logic                  busy1, busy2;
  logic                  issueReady;

  function automatic logic isZeroReg(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign writeEnable = rf.regWrite && !isZeroReg(rf.writeRegister);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (writeEnable) begin
      regs_q[rf.writeRegister] <= rf.writeData;
    end
  end

  // A same-cycle writeback hides both the stale data and the busy bit it is about to clear.
  always_comb begin
    bypassHit1 = 1'b0;
    bypassHit2 = 1'b0;
    readData1  = regs_q[rf.readRegister1];
    readData2  = regs_q[rf.readRegister2];
    busy1      = busy_q[rf.readRegister1];
    busy2      = busy_q[rf.readRegister2];

    if (BYPASS != 0) begin
      bypassHit1 = writeEnable && (rf.writeRegister == rf.readRegister1);
      bypassHit2 = writeEnable && (rf.writeRegister == rf.readRegister2);
    end

    if (bypassHit1) begin
      readData1 = rf.writeData;
      busy1     = 1'b0;
    end
    if (bypassHit2) begin
      readData2 = rf.writeData;
      busy2     = 1'b0;
    end

    if (isZeroReg(rf.readRegister1)) begin
      readData1 = '0;
      busy1     = 1'b0;
    end
    if (isZeroReg(rf.readRegister2)) begin
      readData2 = '0;
      busy2     = 1'b0;
    end
  end

  // A writeback retiring the destination in the same cycle lets a WAW issue through.
  always_comb begin
    issueReady = !busy_q[rf.issueRegister] ||
                 (rf.regWrite && (rf.writeRegister == rf.issueRegister)) ||
                 isZeroReg(rf.issueRegister);
    accept     = rf.issueValid && issueReady && !isZeroReg(rf.issueRegister);
  end

  // Clear first so that a simultaneous set on the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (rf.regWrite) begin
      busy_d[rf.writeRegister] = 1'b0;
    end
    if (accept) begin
      busy_d[rf.issueRegister] = 1'b1;
    end
  end

  always_comb begin
    setsNewBit     = accept && !busy_q[rf.issueRegister];
    clearsOldBit   = rf.regWrite && busy_q[rf.writeRegister] &&
                     !(accept && (rf.issueRegister == rf.writeRegister));
    pendingCount_d = pendingCount_q;
    if (setsNewBit && !clearsOldBit) begin
      pendingCount_d = pendingCount_q + (ADDR_WIDTH+1)'(1);
    end else if (clearsOldBit && !setsNewBit) begin
      pendingCount_d = pendingCount_q - (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q         <= '0;
      pendingCount_q <= '0;
    end else begin
      busy_q         <= busy_d;
      pendingCount_q <= pendingCount_d;
    end
  end

  assign rf.readData1    = readData1;
  assign rf.readData2    = readData2;
  assign rf.busy1        = busy1;
  assign rf.busy2        = busy2;
  assign rf.issueReady   = issueReady;
  assign rf.pendingCount = pendingCount_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one stimulus stream drives a default instance (zero register,
// bypass) and a plain instance (no zero register, no bypass) side by side.
module tb_regfile_scoreboard;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic reset;

  logic [AW-1:0] rr1, rr2, wReg, issueReg;
  logic [DW-1:0] wData;
  logic          regWrite, issueValid;

  int compared;
  int mismatched;

  regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busA ();
  regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busB ();

  assign busA.readRegister1 = rr1;
  assign busA.readRegister2 = rr2;
  assign busA.regWrite      = regWrite;
  assign busA.writeRegister = wReg;
  assign busA.writeData     = wData;
  assign busA.issueValid    = issueValid;
  assign busA.issueRegister = issueReg;

  assign busB.readRegister1 = rr1;
  assign busB.readRegister2 = rr2;
  assign busB.regWrite      = regWrite;
  assign busB.writeRegister = wReg;
  assign busB.writeData     = wData;
  assign busB.issueValid    = issueValid;
  assign busB.issueRegister = issueReg;

  regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(1)) dutA (
    .clk   (clk),
    .reset (reset),
    .rf    (busA.slave)
  );

  regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0), .BYPASS(0)) dutB (
    .clk   (clk),
    .reset (reset),
    .rf    (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                               input logic iv, input logic [AW-1:0] ir,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    regWrite   = we;
    wReg       = wr;
    wData      = wd;
    issueValid = iv;
    issueReg   = ir;
    rr1        = r1;
    rr2        = r2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd5);
    tick();
    tick();
    checkOutput("resetReadA", 64'(busA.readData1), 64'h0);
    checkOutput("resetBusyA", 64'(busA.busy1), 64'h0);
    checkOutput("resetPendA", 64'(busA.pendingCount), 64'h0);
    checkOutput("resetPendB", 64'(busB.pendingCount), 64'h0);
    reset = 1'b0;

    // Write reg5 and issue reg6 together, then reset asynchronously mid-cycle.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 5'd5, 5'd5);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd6);
    checkOutput("wr5ReadA", 64'(busA.readData1), 64'hDEADBEEF);
    checkOutput("wr5ReadB", 64'(busB.readData1), 64'hDEADBEEF);
    checkOutput("iss6BusyA", 64'(busA.busy2), 64'h1);
    checkOutput("iss6PendA", 64'(busA.pendingCount), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncRstReadA", 64'(busA.readData1), 64'h0);
    checkOutput("asyncRstReadB", 64'(busB.readData1), 64'h0);
    checkOutput("asyncRstBusyA", 64'(busA.busy2), 64'h0);
    checkOutput("asyncRstPendA", 64'(busA.pendingCount), 64'h0);
    checkOutput("asyncRstPendB", 64'(busB.pendingCount), 64'h0);
    tick();
    reset = 1'b0;

    // Register 0: hardwired in A, ordinary in B.
    applyStimulus(1'b1, 5'd0, 32'h12345678, 1'b0, '0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
    checkOutput("zeroReadA", 64'(busA.readData1), 64'h0);
    checkOutput("zeroReadB", 64'(busB.readData1), 64'h12345678);
    checkOutput("zeroReadyA", 64'(busA.issueReady), 64'h1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0);
    checkOutput("zeroBusyA", 64'(busA.busy1), 64'h0);
    checkOutput("zeroPendA", 64'(busA.pendingCount), 64'h0);
    checkOutput("zeroBusyB", 64'(busB.busy1), 64'h1);
    checkOutput("zeroPendB", 64'(busB.pendingCount), 64'h1);
    applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, '0, 5'd0, 5'd0);
    tick();
    checkOutput("zeroClrPendB", 64'(busB.pendingCount), 64'h0);

    // Bypass on reg7 while it is busy: A forwards, B shows old data and busy.
    applyStimulus(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 5'd7, 5'd7);
    tick();
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, '0, 5'd7, 5'd7);
    checkOutput("bypRead1A", 64'(busA.readData1), 64'hA5A5A5A5);
    checkOutput("bypRead2A", 64'(busA.readData2), 64'hA5A5A5A5);
    checkOutput("bypBusy1A", 64'(busA.busy1), 64'h0);
    checkOutput("bypBusy2A", 64'(busA.busy2), 64'h0);
    checkOutput("noBypReadB", 64'(busB.readData1), 64'h11111111);
    checkOutput("noBypBusyB", 64'(busB.busy1), 64'h1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd7);
    checkOutput("bypLateReadB", 64'(busB.readData1), 64'hA5A5A5A5);
    checkOutput("bypPendA", 64'(busA.pendingCount), 64'h0);
    checkOutput("bypPendB", 64'(busB.pendingCount), 64'h0);

    // RAW then WAW stall on reg3, released by writeback.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd4);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd4);
    checkOutput("raw3BusyA", 64'(busA.busy1), 64'h1);
    checkOutput("raw3OtherA", 64'(busA.busy2), 64'h0);
    checkOutput("raw3PendA", 64'(busA.pendingCount), 64'h1);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd4);
    checkOutput("waw3ReadyA", 64'(busA.issueReady), 64'h0);
    checkOutput("waw3ReadyB", 64'(busB.issueReady), 64'h0);
    tick();
    checkOutput("waw3PendA", 64'(busA.pendingCount), 64'h1);
    applyStimulus(1'b1, 5'd3, 32'h00000033, 1'b0, '0, 5'd3, 5'd4);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd4);
    checkOutput("wb3BusyA", 64'(busA.busy1), 64'h0);
    checkOutput("wb3PendA", 64'(busA.pendingCount), 64'h0);
    checkOutput("wb3ReadA", 64'(busA.readData1), 64'h33);

    // Issue and writeback of busy reg9 in one cycle: set wins.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
    tick();
    applyStimulus(1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 5'd9, 5'd9);
    checkOutput("iw9ReadyA", 64'(busA.issueReady), 64'h1);
    checkOutput("iw9ReadyB", 64'(busB.issueReady), 64'h1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
    checkOutput("iw9BusyA", 64'(busA.busy1), 64'h1);
    checkOutput("iw9ReadA", 64'(busA.readData1), 64'h99);
    checkOutput("iw9PendA", 64'(busA.pendingCount), 64'h1);
    checkOutput("iw9PendB", 64'(busB.pendingCount), 64'h1);
    applyStimulus(1'b1, 5'd9, 32'h00000099, 1'b0, '0, 5'd9, 5'd9);
    tick();
    checkOutput("clr9PendA", 64'(busA.pendingCount), 64'h0);

    // Fill the scoreboard, then drain it.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, 5'(i), 5'd0, 5'd31);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd31);
    checkOutput("fullPendA", 64'(busA.pendingCount), 64'd31);
    checkOutput("fullPendB", 64'(busB.pendingCount), 64'd32);
    checkOutput("fullBusyB", 64'(busB.busy1), 64'h1);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i), 1'b0, '0, 5'd0, 5'd31);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd31);
    checkOutput("drainPendA", 64'(busA.pendingCount), 64'd0);
    checkOutput("drainPendB", 64'(busB.pendingCount), 64'd0);
    checkOutput("drainReadB", 64'(busB.readData2), 64'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end
endmodule
